// File: rtl/quad_pkg.sv
// Shared types and phase helpers for the quadrature step decoder.
// Phases are named by the filtered {A,B} level pair.
package quad_pkg;

  typedef enum logic [2:0] {
    INIT = 3'd0,
    PH00 = 3'd1,
    PH10 = 3'd2,
    PH11 = 3'd3,
    PH01 = 3'd4
  } phase_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic logic [1:0] phase_code(input phase_t ph);
    logic [1:0] code;
    case (ph)
      PH00:    code = 2'b00;
      PH10:    code = 2'b10;
      PH11:    code = 2'b11;
      PH01:    code = 2'b01;
      default: code = 2'b00;
    endcase
    return code;
  endfunction

  function automatic phase_t phase_of(input logic [1:0] ab);
    phase_t ph;
    case (ab)
      2'b00:   ph = PH00;
      2'b10:   ph = PH10;
      2'b11:   ph = PH11;
      2'b01:   ph = PH01;
      default: ph = PH00;
    endcase
    return ph;
  endfunction

  // Successor of a phase code along the up (A leads B) sequence 00-10-11-01.
  function automatic logic [1:0] up_next(input logic [1:0] ab);
    logic [1:0] nxt;
    case (ab)
      2'b00:   nxt = 2'b10;
      2'b10:   nxt = 2'b11;
      2'b11:   nxt = 2'b01;
      2'b01:   nxt = 2'b00;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  function automatic logic [1:0] down_next(input logic [1:0] ab);
    logic [1:0] nxt;
    case (ab)
      2'b00:   nxt = 2'b01;
      2'b01:   nxt = 2'b11;
      2'b11:   nxt = 2'b10;
      2'b10:   nxt = 2'b00;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/glitch_filter.sv
// Per-channel synchronizer followed by a hold counter: a new level is
// accepted only after it has been stable for FILT_CYCLES cycles.
module glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  localparam int CNT_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   filt_r;
  logic                   sync_s;
  logic [CNT_W-1:0]       cnt_n_s;
  logic                   filt_n_s;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Hold counter: restarts whenever the synchronized level agrees with the filtered one.
  always_comb begin
    cnt_n_s  = {CNT_W{1'b0}};
    filt_n_s = filt_r;
    if (sync_s == filt_r) begin
      cnt_n_s = {CNT_W{1'b0}};
    end else if (cnt_r == CNT_W'(FILT_CYCLES - 1)) begin
      filt_n_s = sync_s;
      cnt_n_s  = {CNT_W{1'b0}};
    end else begin
      cnt_n_s = cnt_r + CNT_W'(1);
    end
  end

  // Synchronizer chain, counter and filtered level registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      filt_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
      cnt_r  <= cnt_n_s;
      filt_r <= filt_n_s;
    end
  end

  assign filt = filt_r;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature decoder: filtered A/B phases drive a Gray-code FSM producing
// step/dir pulses, a sticky illegal-transition flag and a wrap-around position.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int WIDTH       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             err_clr,
  output logic             step,
  output logic             dir,
  output logic [WIDTH-1:0] pos,
  output logic             err
);

  // INIT lasts long enough for the reset-time input levels to reach the filters' outputs.
  localparam int INIT_CYCLES = SYNC_STAGES + FILT_CYCLES + 1;
  localparam int INIT_W      = $clog2(INIT_CYCLES + 1);

  logic              a_filt_s;
  logic              b_filt_s;
  logic [1:0]        ab_s;
  logic [1:0]        cur_s;
  phase_t            state_r;
  phase_t            state_n_s;
  logic [INIT_W-1:0] init_cnt_r;
  logic [INIT_W-1:0] init_cnt_n_s;
  logic              init_done_s;
  logic              step_r;
  logic              step_n_s;
  logic              dir_r;
  logic              dir_n_s;
  logic [WIDTH-1:0]  pos_r;
  logic [WIDTH-1:0]  pos_n_s;
  logic              err_r;
  logic              err_n_s;
  logic              err_set_s;

  glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_filt_a (
    .clk   (clk),
    .reset (reset),
    .raw   (a_in),
    .filt  (a_filt_s)
  );

  glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_filt_b (
    .clk   (clk),
    .reset (reset),
    .raw   (b_in),
    .filt  (b_filt_s)
  );

  assign ab_s        = {a_filt_s, b_filt_s};
  assign cur_s       = phase_code(state_r);
  assign init_done_s = (init_cnt_r == INIT_W'(INIT_CYCLES - 1));

  // Phase FSM next state, step/dir decode and illegal-hop detection.
  always_comb begin
    state_n_s    = state_r;
    init_cnt_n_s = init_cnt_r;
    step_n_s     = 1'b0;
    dir_n_s      = dir_r;
    err_set_s    = 1'b0;
    case (state_r)
      INIT: begin
        if (init_done_s) begin
          state_n_s = phase_of(ab_s);
        end else begin
          init_cnt_n_s = init_cnt_r + INIT_W'(1);
        end
      end
      PH00, PH10, PH11, PH01: begin
        if (ab_s == cur_s) begin
          state_n_s = state_r;
        end else if (ab_s == up_next(cur_s)) begin
          state_n_s = phase_of(ab_s);
          step_n_s  = 1'b1;
          dir_n_s   = DIR_UP;
        end else if (ab_s == down_next(cur_s)) begin
          state_n_s = phase_of(ab_s);
          step_n_s  = 1'b1;
          dir_n_s   = DIR_DOWN;
        end else begin
          state_n_s = phase_of(ab_s);
          err_set_s = 1'b1;
        end
      end
      default: begin
        state_n_s = INIT;
      end
    endcase
  end

  // Position priority is clear, then load, then the step being issued this edge.
  always_comb begin
    pos_n_s = pos_r;
    if (clr) begin
      pos_n_s = {WIDTH{1'b0}};
    end else if (load) begin
      pos_n_s = load_val;
    end else if (step_n_s) begin
      pos_n_s = (dir_n_s == DIR_UP) ? pos_r + WIDTH'(1) : pos_r - WIDTH'(1);
    end else begin
      pos_n_s = pos_r;
    end
  end

  // Sticky error: a new error outranks a simultaneous clear.
  always_comb begin
    err_n_s = err_r;
    if (err_set_s) begin
      err_n_s = 1'b1;
    end else if (err_clr) begin
      err_n_s = 1'b0;
    end else begin
      err_n_s = err_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= INIT;
      init_cnt_r <= {INIT_W{1'b0}};
      step_r     <= 1'b0;
      dir_r      <= DIR_UP;
      pos_r      <= {WIDTH{1'b0}};
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      init_cnt_r <= init_cnt_n_s;
      step_r     <= step_n_s;
      dir_r      <= dir_n_s;
      pos_r      <= pos_n_s;
      err_r      <= err_n_s;
    end
  end

  assign step = step_r;
  assign dir  = dir_r;
  assign pos  = pos_r;
  assign err  = err_r;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder: a phase-index/position model predicts
// each step pulse (dir, pos, arrival cycle); a monitor compares every pulse.
module tb_quad_step_decoder;

  localparam int S           = 2;
  localparam int F           = 4;
  localparam int W           = 4;
  localparam int L           = S + F;
  localparam int INIT_CYCLES = S + F + 1;
  localparam int MOD         = 1 << W;

  logic         clk = 1'b0;
  logic         reset;
  logic         a_in, b_in, clr, load, err_clr;
  logic [W-1:0] load_val;
  logic         step, dir, err;
  logic [W-1:0] pos;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic         d;
    logic [W-1:0] p;
    int           c;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] seq[4];
  int         idx;
  int         mpos;

  quad_step_decoder #(.SYNC_STAGES(S), .FILT_CYCLES(F), .WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .a_in     (a_in),
    .b_in     (b_in),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .err_clr  (err_clr),
    .step     (step),
    .dir      (dir),
    .pos      (pos),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic drive_idx(input int i);
    a_in = seq[i][1];
    b_in = seq[i][0];
  endtask

  // One legal quadrature hop; the model predicts the pulse L+1 cycles out.
  task automatic hop(input bit down, input int hold);
    exp_t e;
    idx  = down ? (idx + 3) % 4 : (idx + 1) % 4;
    mpos = down ? (mpos + MOD - 1) % MOD : (mpos + 1) % MOD;
    drive_idx(idx);
    e.d = down;
    e.p = W'(mpos);
    e.c = cyc + 1 + L;
    sb.push_back(e);
    repeat (hold) @(negedge clk);
  endtask

  task automatic quiet();
    repeat (L + 3) @(negedge clk);
  endtask

  task automatic pos_op(input bit do_clr, input int val);
    if (do_clr) begin
      clr  = 1'b1;
      mpos = 0;
    end else begin
      load     = 1'b1;
      load_val = W'(val);
      mpos     = val % MOD;
    end
    @(negedge clk);
    clr  = 1'b0;
    load = 1'b0;
    chk(do_clr ? "clr_pos" : "load_pos", int'(pos), mpos);
  endtask

  // Monitor: every step pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && step === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_step: dir=%0d pos=%0d cycle=%0d, none expected", dir, pos, cyc);
        end else begin
          e = sb.pop_front();
          if (dir !== e.d || pos !== e.p || cyc != e.c) begin
            errors++;
            $display("FAIL step: got dir=%0d pos=%0d cycle=%0d expected dir=%0d pos=%0d cycle=%0d",
                     dir, pos, cyc, e.d, e.p, e.c);
          end
        end
      end
    end
  end

  initial begin
    exp_t e;
    int   ch, len, hold;
    seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
    reset = 1'b1; a_in = 1'b1; b_in = 1'b1;
    clr = 1'b0; load = 1'b0; err_clr = 1'b0; load_val = '0;
    repeat (3) @(negedge clk);
    chk("reset_step", int'(step), 0);
    chk("reset_dir", int'(dir), 0);
    chk("reset_pos", int'(pos), 0);
    chk("reset_err", int'(err), 0);

    // Release with both phases high: INIT settles into phase 11 silently.
    reset = 1'b0;
    idx = 2; mpos = 0;
    repeat (INIT_CYCLES + 3) @(negedge clk);
    chk("init_err", int'(err), 0);
    chk("init_pos", int'(pos), 0);

    pos_op(1'b0, 14);
    for (int i = 0; i < 4; i++) hop(1'b0, F + 1);
    quiet();
    chk("up_pos", int'(pos), 2);

    pos_op(1'b1, 0);
    for (int i = 0; i < 2; i++) hop(1'b1, F);
    quiet();
    chk("down_pos", int'(pos), 14);
    chk("down_dir", int'(dir), 1);

    // Three-cycle pulse on A from phase 00 must be rejected.
    a_in = 1'b1;
    repeat (F - 1) @(negedge clk);
    a_in = 1'b0;
    repeat (L + 4) @(negedge clk);
    chk("glitch_pos", int'(pos), 14);

    // Illegal 00 -> 11.
    idx = 2; drive_idx(idx);
    repeat (L + 2) @(negedge clk);
    chk("illegal_err", int'(err), 1);
    chk("illegal_pos", int'(pos), 14);
    chk("illegal_dir", int'(dir), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", int'(err), 0);

    // Illegal 11 -> 00 while err_clr is held: the set wins on the error edge.
    idx = 0; drive_idx(idx);
    err_clr = 1'b1;
    repeat (L + 1) @(negedge clk);
    chk("err_set_wins", int'(err), 1);
    @(negedge clk);
    chk("err_clr_after", int'(err), 0);
    err_clr = 1'b0;
    quiet();

    // Up step coinciding with load: pulse still issued, pos takes load_val.
    idx = 1; drive_idx(idx);
    e.d = 1'b0; e.p = W'(5); e.c = cyc + 1 + L;
    sb.push_back(e);
    repeat (L) @(negedge clk);
    load = 1'b1; load_val = W'(5);
    @(negedge clk);
    load = 1'b0;
    mpos = 5;
    quiet();
    chk("load_step_pos", int'(pos), 5);

    // Randomised hops with periodic glitches and position operations.
    for (int n = 0; n < 48; n++) begin
      hold = $urandom_range(F, F + 5);
      hop(1'($urandom_range(0, 1)), hold);
      if (n % 12 == 11) begin
        quiet();
        ch  = $urandom_range(0, 1);
        len = $urandom_range(1, F - 1);
        if (ch == 0) a_in = ~a_in; else b_in = ~b_in;
        repeat (len) @(negedge clk);
        drive_idx(idx);
        repeat (L + 2) @(negedge clk);
        chk("rand_glitch_pos", int'(pos), mpos);
        pos_op(1'($urandom_range(0, 1)), $urandom_range(0, MOD - 1));
      end
    end
    quiet();
    chk("rand_final_pos", int'(pos), mpos);

    // Reset in the middle of a filter count.
    pos_op(1'b0, 9);
    hop(1'b1, F);
    quiet();
    a_in = ~a_in;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset_step", int'(step), 0);
    chk("midreset_dir", int'(dir), 0);
    chk("midreset_pos", int'(pos), 0);
    chk("midreset_err", int'(err), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) if (seq[i] == {a_in, b_in}) idx = i;
    mpos = 0;
    repeat (INIT_CYCLES + L) @(negedge clk);
    chk("reinit_pos", int'(pos), 0);
    chk("reinit_err", int'(err), 0);
    hop(1'b0, F);
    quiet();
    chk("recover_pos", int'(pos), 1);
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
